// File: rtl/weight_mem_ctrl_pkg.sv
// Shared state encoding and default widths for the weight memory controller.
package weight_mem_ctrl_pkg;

  localparam int unsigned DEF_DATA_W = 8;
  localparam int unsigned DEF_ADDR_W = 4;
  localparam int unsigned DEF_ACC_W  = 20;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StRd,
    StMac,
    StDone
  } state_e;

endpackage

// File: rtl/weight_mem_ctrl_mac.sv
// Signed multiply-accumulate: DATA_W x DATA_W product, sign-extended into an ACC_W accumulator
// that can be initialised (clear) or advanced (enable).
module wmc_mac
  import weight_mem_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ACC_W  = DEF_ACC_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_clr,
  input  logic              i_en,
  input  logic [ACC_W-1:0]  i_init,
  input  logic [DATA_W-1:0] i_w,
  input  logic [DATA_W-1:0] i_x,
  output logic [ACC_W-1:0]  o_acc_next
);

  logic signed [2*DATA_W-1:0] w_prod;
  logic        [ACC_W-1:0]    w_prod_ext;
  logic        [ACC_W-1:0]    r_acc;

  assign w_prod     = $signed(i_w) * $signed(i_x);
  assign w_prod_ext = {{(ACC_W - 2 * DATA_W){w_prod[2*DATA_W-1]}}, w_prod};
  assign o_acc_next = r_acc + w_prod_ext;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
    end else if (i_clr) begin
      r_acc <= i_init;
    end else if (i_en) begin
      r_acc <= o_acc_next;
    end
  end

endmodule

// File: rtl/weight_mem_ctrl.sv
// Weight memory controller: streams weights into an external memory, then computes a signed
// dot product against a feature stream. Define WEIGHT_MEM_CTRL_BIAS_EN to add a bias beat.
module weight_mem_ctrl
  import weight_mem_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned ACC_W  = DEF_ACC_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_load,
  input  logic              start,
  input  logic [ADDR_W-1:0] n_feat,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  output logic              load_ready,
  input  logic              x_valid,
  input  logic [DATA_W-1:0] x_data,
  output logic              x_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_data,
  input  logic [DATA_W-1:0] mem_out,
  output logic [ACC_W-1:0]  y,
  output logic              y_valid,
  output logic              busy
);

  state_e            r_state;
  logic [ADDR_W-1:0] r_idx;
  logic [ADDR_W-1:0] r_len;
  logic [ACC_W-1:0]  r_y;

  logic              w_last;
  logic              w_run_go;
  logic              w_x_hs;
  logic [ACC_W-1:0]  w_init;
  logic [ACC_W-1:0]  w_acc_next;

`ifdef WEIGHT_MEM_CTRL_BIAS_EN
  logic [DATA_W-1:0] r_bias;
  logic              r_bias_ph;

  assign w_init = {{(ACC_W - DATA_W){r_bias[DATA_W-1]}}, r_bias};
`else
  assign w_init = '0;
`endif

  assign w_last   = (r_idx == r_len);
  assign w_run_go = (r_state == StIdle) && start && !cmd_load;
  assign w_x_hs   = (r_state == StMac) && x_valid;

  wmc_mac #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_clr      (w_run_go),
    .i_en       (w_x_hs),
    .i_init     (w_init),
    .i_w        (mem_out),
    .i_x        (x_data),
    .o_acc_next (w_acc_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= StIdle;
      r_idx     <= '0;
      r_len     <= '0;
      r_y       <= '0;
`ifdef WEIGHT_MEM_CTRL_BIAS_EN
      r_bias    <= '0;
      r_bias_ph <= 1'b0;
`endif
    end else begin
      unique case (r_state)
        StIdle: begin
          if (cmd_load) begin
            r_state   <= StLoad;
            r_len     <= n_feat;
            r_idx     <= '0;
`ifdef WEIGHT_MEM_CTRL_BIAS_EN
            r_bias_ph <= 1'b0;
`endif
          end else if (start) begin
            r_state <= StRd;
            r_len   <= n_feat;
            r_idx   <= '0;
          end
        end
        StLoad: begin
          if (load_valid) begin
`ifdef WEIGHT_MEM_CTRL_BIAS_EN
            // Beat after the last weight carries the bias; idx is not advanced past len.
            if (r_bias_ph) begin
              r_bias    <= load_data;
              r_bias_ph <= 1'b0;
              r_state   <= StIdle;
            end else if (w_last) begin
              r_bias_ph <= 1'b1;
            end else begin
              r_idx <= r_idx + 1'b1;
            end
`else
            if (w_last) begin
              r_state <= StIdle;
            end else begin
              r_idx <= r_idx + 1'b1;
            end
`endif
          end
        end
        StRd: begin
          r_state <= StMac;
        end
        StMac: begin
          if (x_valid) begin
            if (w_last) begin
              r_state <= StDone;
              r_y     <= w_acc_next;
            end else begin
              r_idx   <= r_idx + 1'b1;
              r_state <= StRd;
            end
          end
        end
        StDone: begin
          r_state <= StIdle;
        end
        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

  always_comb begin
    load_ready = 1'b0;
    mem_wr     = 1'b0;
    mem_addr   = '0;
    x_ready    = 1'b0;
    y_valid    = 1'b0;
    unique case (r_state)
      StLoad: begin
        load_ready = 1'b1;
        mem_addr   = r_idx;
`ifdef WEIGHT_MEM_CTRL_BIAS_EN
        mem_wr     = load_valid && !r_bias_ph;
`else
        mem_wr     = load_valid;
`endif
      end
      // Address stays on idx through MAC so the read data remains stable while stalled.
      StRd:    mem_addr = r_idx;
      StMac: begin
        mem_addr = r_idx;
        x_ready  = 1'b1;
      end
      StDone:  y_valid = 1'b1;
      default: ;
    endcase
  end

  assign mem_data = load_data;
  assign y        = r_y;
  assign busy     = (r_state != StIdle);

endmodule

// File: tb/tb_weight_mem_ctrl.sv
// Directed self-checking bench for weight_mem_ctrl with a behavioural synchronous weight memory.
module tb_weight_mem_ctrl;

  localparam int DW = 8;
  localparam int AW = 4;
  localparam int CW = 20;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_load = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] n_feat = '0;
  logic          load_valid = 1'b0;
  logic [DW-1:0] load_data = '0;
  logic          load_ready;
  logic          x_valid = 1'b0;
  logic [DW-1:0] x_data = '0;
  logic          x_ready;
  logic [AW-1:0] mem_addr;
  logic          mem_wr;
  logic [DW-1:0] mem_data;
  logic [DW-1:0] mem_out;
  logic [CW-1:0] y;
  logic          y_valid;
  logic          busy;

  logic [DW-1:0] mem [16];
  logic [DW-1:0] wv [16];
  logic [DW-1:0] xv [16];
  int            wr_count = 0;
  int            yv_count = 0;
  int            checks = 0;
  int            failures = 0;

  weight_mem_ctrl u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_load   (cmd_load),
    .start      (start),
    .n_feat     (n_feat),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_ready (load_ready),
    .x_valid    (x_valid),
    .x_data     (x_data),
    .x_ready    (x_ready),
    .mem_addr   (mem_addr),
    .mem_wr     (mem_wr),
    .mem_data   (mem_data),
    .mem_out    (mem_out),
    .y          (y),
    .y_valid    (y_valid),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_wr === 1'b1) begin
      mem[mem_addr] <= mem_data;
      wr_count++;
    end
    mem_out <= mem[mem_addr];
    if (y_valid === 1'b1) yv_count++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_load(input int n, input logic both, input logic [DW-1:0] bias);
    @(negedge clk);
    n_feat   = AW'(n);
    cmd_load = 1'b1;
    start    = both;
    @(negedge clk);
    cmd_load = 1'b0;
    start    = 1'b0;
    for (int i = 0; i <= n; i++) begin
      load_valid = 1'b1;
      load_data  = wv[i];
      #1;
      if (i == 0) check("load_ready", 32'(load_ready), 32'd1);
      check("load_addr", 32'(mem_addr), 32'(i));
      @(negedge clk);
    end
`ifdef WEIGHT_MEM_CTRL_BIAS_EN
    load_valid = 1'b1;
    load_data  = bias;
    #1;
    check("bias_no_wr", 32'(mem_wr), 32'd0);
    @(negedge clk);
`else
    if (bias != 0) $display("note: bias beat skipped in this build");
`endif
    load_valid = 1'b0;
    #1;
    check("load_idle", 32'(busy), 32'd0);
  endtask

  // stall_at >= 0 inserts three idle MAC cycles (with stray commands) before that feature.
  task automatic do_run(input int n, input int stall_at, input logic [31:0] exp_y,
                        input string tag);
    int t;
    yv_count = 0;
    @(negedge clk);
    n_feat = AW'(n);
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i <= n; i++) begin
      if (i == stall_at) begin
        x_valid = 1'b0;
        @(negedge clk);
        for (int s = 0; s < 3; s++) begin
          #1;
          check("stall_xready", 32'(x_ready), 32'd1);
          cmd_load = (s == 0);
          start    = (s == 0);
          @(negedge clk);
        end
        cmd_load = 1'b0;
        start    = 1'b0;
      end
      x_valid = 1'b1;
      x_data  = xv[i];
      t = 0;
      #1;
      while (!x_ready && t < 8) begin
        @(negedge clk);
        #1;
        t++;
      end
      if (t == 8) check("xready_timeout", 32'd0, 32'd1);
      @(negedge clk);
      x_valid = 1'b0;
    end
    t = 0;
    #1;
    while (!y_valid && t < 8) begin
      @(negedge clk);
      #1;
      t++;
    end
    check({tag, "_yvalid"}, 32'(y_valid), 32'd1);
    check({tag, "_y"}, 32'(y), exp_y);
    repeat (3) @(negedge clk);
    #1;
    check({tag, "_pulses"}, 32'(yv_count), 32'd1);
    check({tag, "_y_hold"}, 32'(y), exp_y);
  endtask

  initial begin
    #3;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_y", 32'(y), 32'd0);
    check("rst_yvalid", 32'(y_valid), 32'd0);
    check("rst_ready", {30'd0, load_ready, x_ready}, 32'd0);
    check("rst_mem", {27'd0, mem_wr, mem_addr}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1*4 + 2*5 + 3*6 = 32
    wv[0] = 8'h01; wv[1] = 8'h02; wv[2] = 8'h03;
    xv[0] = 8'd4;  xv[1] = 8'd5;  xv[2] = 8'd6;
    wr_count = 0;
    do_load(2, 1'b0, 8'h00);
    check("wr_count", 32'(wr_count), 32'd3);
    check("mem0", 32'(mem[0]), 32'h01);
    check("mem1", 32'(mem[1]), 32'h02);
    check("mem2", 32'(mem[2]), 32'h03);
    do_run(2, -1, 32'd32, "basic");

    // Stalled run with stray cmd_load/start pulses inside MAC
    do_run(2, 1, 32'd32, "stall");
    check("stall_no_wr", 32'(wr_count), 32'd3);

    // -1 * 127 = -127; load entered with cmd_load and start together
    wv[0] = 8'hFF; xv[0] = 8'h7F;
    do_load(0, 1'b1, 8'h00);
    check("both_wr", 32'(wr_count), 32'd4);
    do_run(0, -1, 32'h000F_FF81, "neg");

    // 16 * (-128 * -128) = 262144
    for (int i = 0; i < 16; i++) begin
      wv[i] = 8'h80;
      xv[i] = 8'h80;
    end
    do_load(15, 1'b0, 8'h00);
    do_run(15, -1, 32'h0004_0000, "max");

    // Reset in the middle of a run
    wv[0] = 8'h01; wv[1] = 8'h02; wv[2] = 8'h03;
    xv[0] = 8'd4;  xv[1] = 8'd5;  xv[2] = 8'd6;
    do_load(2, 1'b0, 8'h00);
    @(negedge clk);
    n_feat = 2;
    start  = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    x_valid = 1'b1;
    x_data  = 8'd4;
    @(negedge clk);
    @(negedge clk);
    x_valid = 1'b0;
    @(negedge clk);
    #1;
    check("mid_xready", 32'(x_ready), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_y", 32'(y), 32'd0);
    check("mid_rst_out", {28'd0, x_ready, load_ready, mem_wr, y_valid}, 32'd0);
    check("mid_rst_addr", 32'(mem_addr), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    do_run(2, -1, 32'd32, "after_rst");

`ifdef WEIGHT_MEM_CTRL_BIAS_EN
    // 32 + (-10) = 22
    wr_count = 0;
    do_load(2, 1'b0, 8'hF6);
    check("bias_wr_count", 32'(wr_count), 32'd3);
    do_run(2, -1, 32'd22, "bias");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
